// File: rtl/pfq_pkg.sv
// Shared widths, queue entry type and a saturating counter helper
// for the instruction prefetch queue.
package pfq_pkg;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;

    typedef logic [ADDR_W-1:0] pfq_addr_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } pfq_entry_t;

    function automatic logic [15:0] sat_inc16(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Prefetch queue bus: instruction-memory read port plus decode-side
// valid/stall handshake and redirect input.
interface instr_prefetch_queue_if;
    import pfq_pkg::*;

    logic               imem_req;
    pfq_addr_t          imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    pfq_addr_t          redirect_pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_code;
    pfq_addr_t          pc_out;
    pfq_addr_t          pc_next;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_code, pc_out, pc_next,
        input  imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_code, pc_out, pc_next,
        output imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/pfq_fifo.sv
// Small in-order FIFO with synchronous flush; head is read straight from
// registered storage so nothing combinational reaches it from wdata.
module pfq_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  T                             wdata,
    output T                             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    typedef logic [PW-1:0] ptr_t;

    T     mem [DEPTH];
    ptr_t wr_ptr, rd_ptr;
    logic do_push, do_pop;

    // Depth need not be a power of two (tag FIFO), so wrap explicitly.
    function automatic ptr_t bump(ptr_t p);
        return (p == ptr_t'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: sequential PC generation, in-order response
// queue, redirect flush. Define PFQ_PERF_EN to add the perf counter ports.
module instr_prefetch_queue
    import pfq_pkg::*;
#(
    parameter int        DEPTH           = 4,
    parameter int        MAX_OUTSTANDING = 2,
    parameter pfq_addr_t RESET_PC        = 8'h00
) (
    input  logic                    clk,
    input  logic                    reset,
    instr_prefetch_queue_if.master  bus
`ifdef PFQ_PERF_EN
    ,
    output logic [15:0]             perf_empty_cycles,
    output logic [15:0]             perf_dropped
`endif
);
    localparam int QCW = $clog2(DEPTH+1);
    localparam int OCW = $clog2(MAX_OUTSTANDING+1);

    pfq_addr_t        fetch_pc;
    logic [OCW-1:0]   outstanding;
    logic [OCW-1:0]   drop_cnt;

    pfq_entry_t       q_head, q_wdata;
    logic [QCW-1:0]   q_count;
    logic             q_full, q_empty;
    pfq_addr_t        t_head;
    logic [OCW-1:0]   t_count;
    logic             t_full, t_empty;
    logic             unused_fifo_status;

    logic issue, resp, accept, drop, pop;

    always_comb begin
        issue   = !reset && !bus.redirect
                  && (int'(q_count) + int'(outstanding) < DEPTH)
                  && (int'(outstanding) < MAX_OUTSTANDING);
        // A response with nothing in flight is a protocol error: ignore it.
        resp    = bus.imem_rvalid && (outstanding != '0);
        accept  = resp && (drop_cnt == '0) && !bus.redirect;
        drop    = resp && !accept;
        pop     = !q_empty && !bus.stall && !bus.redirect;
        q_wdata = '{instr: bus.imem_rdata, pc: t_head};
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = !q_empty;
    assign bus.instr_code  = q_head.instr;
    assign bus.pc_out      = q_head.pc;
    assign bus.pc_next     = q_head.pc + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({issue, resp})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            // Everything still in flight after this cycle belongs to the old path.
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
                drop_cnt <= outstanding - OCW'(resp);
            end else begin
                if (issue) fetch_pc <= fetch_pc + 8'd1;
                if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    pfq_fifo #(.DEPTH(DEPTH), .T(pfq_entry_t)) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect),
        .push  (accept),
        .pop   (pop),
        .wdata (q_wdata),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Tags of live requests only; dropped responses never consume a tag.
    pfq_fifo #(.DEPTH(MAX_OUTSTANDING), .T(pfq_addr_t)) u_tags (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect),
        .push  (issue),
        .pop   (accept),
        .wdata (fetch_pc),
        .head  (t_head),
        .full  (t_full),
        .empty (t_empty),
        .count (t_count)
    );

    assign unused_fifo_status = ^{q_full, t_full, t_empty, t_count};

`ifdef PFQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_empty_cycles <= '0;
            perf_dropped      <= '0;
        end else begin
            if (q_empty) perf_empty_cycles <= sat_inc16(perf_empty_cycles);
            if (drop)    perf_dropped      <= sat_inc16(perf_dropped);
        end
    end
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_instr_prefetch_queue;
    import pfq_pkg::*;

    localparam int        DEPTH = 4;
    localparam int        MAXO  = 2;
    localparam logic [7:0] RPC  = 8'h00;

    logic clk = 1'b0;
    logic reset;
    instr_prefetch_queue_if bus();
`ifdef PFQ_PERF_EN
    logic [15:0] perf_empty_cycles, perf_dropped;
`endif

    instr_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PFQ_PERF_EN
        ,
        .perf_empty_cycles (perf_empty_cycles),
        .perf_dropped      (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] pc; bit stale; }      fl_t;
    typedef struct { logic [7:0] instr; logic [7:0] pc; } ent_t;
    typedef struct { logic [7:0] addr; int due; }      mreq_t;

    fl_t   infl[$];   // requests in flight, oldest first
    ent_t  outq[$];   // instructions visible to decode
    mreq_t pend[$];   // memory model pending responses

    logic [7:0] fpc, rpc;
    bit         rst, red, stl;
    int         cyc, last_due, lat, total, bad, m_empty, m_drop;

    function automatic logic [7:0] mem_f(logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance model and memory.
    task automatic step();
        bit         rv, resp, ereq;
        fl_t        f;
        int         d;
        logic [7:0] nx;
        reset           = rst;
        bus.stall       = stl;
        bus.redirect    = red;
        bus.redirect_pc = rpc;
        rv = !rst && (pend.size() > 0) && (pend[0].due <= cyc);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_f(pend[0].addr) : 8'($urandom);
        #1;
        ereq = !rst && !red && (outq.size() + infl.size() < DEPTH) && (infl.size() < MAXO);
        chk("imem_req", 32'(bus.imem_req), 32'(ereq));
        if (ereq) chk("imem_addr", 32'(bus.imem_addr), 32'(fpc));
        if (!rst) begin
            chk("instr_valid", 32'(bus.instr_valid), 32'(outq.size() > 0));
            if (outq.size() > 0) begin
                nx = outq[0].pc + 8'd1;
                chk("instr_code", 32'(bus.instr_code), 32'(outq[0].instr));
                chk("pc_out", 32'(bus.pc_out), 32'(outq[0].pc));
                chk("pc_next", 32'(bus.pc_next), 32'(nx));
            end
`ifdef PFQ_PERF_EN
            chk("perf_empty", 32'(perf_empty_cycles), 32'(m_empty));
            chk("perf_dropped", 32'(perf_dropped), 32'(m_drop));
`endif
        end
        if (rv) void'(pend.pop_front());
        if (bus.imem_req === 1'b1) begin
            d = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{bus.imem_addr, d});
            last_due = d;
        end
        if (rst) begin
            infl.delete(); outq.delete(); pend.delete();
            fpc = RPC; last_due = cyc; m_empty = 0; m_drop = 0;
        end else begin
            resp = rv && (infl.size() > 0);
            if (outq.size() == 0 && m_empty < 65535) m_empty++;
            if (red) begin
                outq.delete();
                if (resp) begin
                    void'(infl.pop_front());
                    if (m_drop < 65535) m_drop++;
                end
                foreach (infl[i]) infl[i].stale = 1'b1;
                fpc = rpc;
            end else begin
                if (outq.size() > 0 && !stl) void'(outq.pop_front());
                if (resp) begin
                    f = infl.pop_front();
                    if (f.stale) begin
                        if (m_drop < 65535) m_drop++;
                    end else outq.push_back('{mem_f(f.pc), f.pc});
                end
                if (ereq) begin
                    infl.push_back('{fpc, 1'b0});
                    fpc = fpc + 8'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        int k;
        total = 0; bad = 0; cyc = 0; last_due = 0; lat = 1;
        m_empty = 0; m_drop = 0; fpc = RPC;
        rst = 1; red = 0; stl = 0; rpc = 8'h00;

        // Reset, then 1-cycle memory fill
        step();
        rst = 0;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_code", 32'(bus.instr_code), 32'd0);
        chk("rst_pc_out", 32'(bus.pc_out), 32'd0);
        chk("rst_pc_next", 32'(bus.pc_next), 32'd1);
        step(); step();
        chk("first_valid", 32'(bus.instr_valid), 32'd1);
        chk("first_code", 32'(bus.instr_code), 32'h5A);
        chk("first_pc", 32'(bus.pc_out), 32'h00);
        chk("first_pc_next", 32'(bus.pc_next), 32'h01);
        repeat (5) step();

        // Hold stall: queue fills, requests stop
        stl = 1;
        repeat (10) step();
        chk("stall_req_off", 32'(bus.imem_req), 32'd0);
        chk("stall_valid", 32'(bus.instr_valid), 32'd1);
        stl = 0;
        repeat (8) step();

        // 2-cycle memory, redirect with two reads in flight
        lat = 2;
        for (int i = 0; i < 20 && infl.size() != 2; i++) step();
        chk("two_inflight", 32'(infl.size()), 32'd2);
        red = 1; rpc = 8'h40;
        step();
        red = 0;
        for (int i = 0; i < 20 && outq.size() == 0; i++) step();
        chk("redir_pc", 32'(bus.pc_out), 32'h40);
        chk("redir_code", 32'(bus.instr_code), 32'h1A);
        repeat (4) step();

        // Redirect together with a pop and an arriving response
        lat = 1;
        for (int i = 0; i < 30 && !(outq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc); i++) step();
        chk("combo_setup", 32'(outq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc), 32'd1);
        red = 1; rpc = 8'h80;
        step();
        red = 0;
        chk("combo_empty", 32'(bus.instr_valid), 32'd0);
        repeat (6) step();

        // PC wrap through 8'hFF
        exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
        red = 1; rpc = 8'hFE;
        step();
        red = 0;
        k = 0;
        for (int i = 0; i < 30 && k < 4; i++) begin
            if (bus.instr_valid === 1'b1) begin
                chk("wrap_pc", 32'(bus.pc_out), 32'(exp_seq[k]));
                if (k == 1) chk("wrap_pc_next", 32'(bus.pc_next), 32'h00);
                k++;
            end
            step();
        end
        chk("wrap_count", k, 4);

        // Mid-stream reset with two entries queued
        stl = 1;
        for (int i = 0; i < 20 && outq.size() != 2; i++) step();
        chk("two_queued", 32'(outq.size()), 32'd2);
        rst = 1;
        step();
        rst = 0; stl = 0;
        chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
`ifdef PFQ_PERF_EN
        chk("midrst_perf_empty", 32'(perf_empty_cycles), 32'd0);
        chk("midrst_perf_drop", 32'(perf_dropped), 32'd0);
`endif
        repeat (6) step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            stl = ($urandom % 10) < 3;
            red = ($urandom % 20) == 0;
            rpc = (($urandom % 4) == 0) ? 8'(8'hFC + ($urandom % 4)) : 8'($urandom);
            rst = ($urandom % 300) == 0;
            lat = 1 + ($urandom % 3);
            step();
        end
        rst = 0; red = 0; stl = 0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register.
- Generates sequential 8-bit PCs, issues reads to instruction memory and buffers returned 8-bit instructions in a small in-order queue.
- Presents instruction plus PC to the decode stage with a valid/stall handshake.
- On a jump, flushes the queue and in-flight reads, then refetches from the redirect target.

Parameters:
- DEPTH, 4, queue entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2, maximum memory reads in flight (1..3).
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request this cycle.
- imem_addr  output  8  read address, valid when imem_req=1.
- imem_rvalid  input  1  read data returned; in request order; ≥1 cycle after its request.
- imem_rdata  input  8  returned instruction.
- stall  input  1  decode cannot accept this cycle.
- redirect  input  1  jump taken; flush and refetch.
- redirect_pc  input  8  jump target.
- instr_valid  output  1  instr_code/pc_out hold a valid instruction.
- instr_code  output  8  head-of-queue instruction.
- pc_out  output  8  address of instr_code.
- pc_next  output  8  pc_out+1, modulo 256.

Behaviour:
- Reset (clk edge with reset=1):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - Outputs: imem_req=0, instr_valid=0, instr_code=0, pc_out=0, pc_next=1.
- Request issue:
  - imem_req=1 when !reset, !redirect, and count+outstanding < DEPTH and outstanding < MAX_OUTSTANDING.
  - imem_addr=fetch_pc (combinational).
  - On issue, fetch_pc increments and wraps 8'hFF -> 8'h00. The issued address goes into a MAX_OUTSTANDING-deep tag FIFO.
- Response:
  - When imem_rvalid=1 and drop_cnt=0, push {imem_rdata, tag} at the edge; instr_valid rises the next cycle.
  - When drop_cnt>0, the response is discarded and drop_cnt decrements.
  - outstanding decrements on every imem_rvalid.
  - imem_rvalid with outstanding=0 is a protocol error and is ignored.
- Pop: when instr_valid=1 and stall=0, the head is consumed at the edge. Outputs show the new head, or instr_valid=0 if the queue is now empty.
- Simultaneous push and pop: both take effect and count is unchanged. A push to a full queue cannot occur by construction of the issue rule.
- Redirect (wins over all other events in the same cycle):
  - Queue emptied; pop ignored.
  - drop_cnt = outstanding minus any response arriving this cycle. That response is also dropped.
  - fetch_pc=redirect_pc; no request this cycle.
  - First request to redirect_pc goes out on the following cycle.
  - Minimum latency redirect→instr_valid is 3 cycles with 1-cycle memory.
- Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Reset mid-operation: all state returns to reset values. Responses to pre-reset requests arriving after reset are a system error (memory is reset together with this block).
- Steady state, 1-cycle memory, no stalls: one instruction per cycle after a 2-cycle fill.
- Outputs are driven from registered state only (instr_code, pc_out, pc_next from queue head); no combinational path from imem_rdata to instr_code.

Optional Feature:
- Macro: PFQ_PERF_EN.
- Defined:
  - Adds output ports perf_empty_cycles[15:0] and perf_dropped[15:0].
  - perf_empty_cycles counts cycles with instr_valid=0 after reset.
  - perf_dropped counts discarded responses.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pfq_pkg: ADDR_W=8, INSTR_W=8, typedef pfq_entry_t {instr[7:0], pc[7:0]}.
- One sub-module, pfq_fifo:
  - Parameterised DEPTH; synchronous flush; push/pop/full/empty/count; registered head output.
  - Instantiated once for the queue and once (entry = pc only, depth MAX_OUTSTANDING) for the address tags.

Test Plan:
- Reset, 1-cycle memory returning mem[a]=a^8'h5A, stall=0:
  - imem_addr 0,1,2,...
  - First instr_valid on cycle 3 with instr_code=8'h5A, pc_out=0, pc_next=1; then one instruction per cycle in order.
- Hold stall=1 for 10 cycles from cycle 3:
  - instr_valid stays 1 with pc_out=0.
  - At most DEPTH+outstanding requests issued, then imem_req=0.
  - On release, pc_out steps 0,1,2,3,4 with no gaps or duplicates.
- 2-cycle memory, redirect=1 with redirect_pc=8'h40 while 2 reads are in flight:
  - Both stale responses dropped.
  - Next valid output is pc_out=8'h40, instr_code=mem[8'h40].
- Redirect and pop in the same cycle, plus a response arriving that cycle: queue empty next cycle and no stale instruction ever appears.
- RESET_PC=8'hFE: pc_out sequence FE, FF, 00, 01; pc_next at FF is 00.
- Assert reset for 1 cycle mid-stream with 2 entries queued: next cycle instr_valid=0 and imem_req=0, then fetch resumes from RESET_PC. With PFQ_PERF_EN, both counters read 0 after reset.
